// File: rtl/topk_net_pkg.sv
// Shared definitions for the top-k network RX/TX paths: stream widths,
// packed output-word field offsets, notification layout and the RX FSM states.
// No ports. The ceil-to-beats helper is used by pkt_receiver.
package topk_net_pkg;

   localparam int NOTIF_W     = 88;
   localparam int READ_REQ_W  = 32;
   localparam int PKT_W       = 545;
   localparam int SESSION_LSB = 513;
   localparam int TLAST_BIT   = 512;
   localparam int BEAT_BYTES  = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      META = 2'd2,
      DATA = 2'd3
   } rx_state_e;

   // Session notification as delivered by the TCP/IP stack (88 bits).
   typedef struct packed {
      logic [6:0]  rsvd;
      logic        closed;
      logic [15:0] port;
      logic [31:0] ip;
      logic [15:0] length;
      logic [15:0] session_id;
   } notif_t;

   // Number of data beats for a byte length; 17 bits so 0xFFFF+63 cannot wrap.
   function automatic logic [16:0] beats_for_len(input logic [15:0] len);
      return 17'(({1'b0, len} + 17'(BEAT_BYTES - 1)) >> $clog2(BEAT_BYTES));
   endfunction

endpackage

// File: rtl/pkt_receiver_if.sv
// Generic AXI-stream style bundle: TDATA/TKEEP/TLAST with TVALID/TREADY.
// Ports: master drives TDATA/TKEEP/TLAST/TVALID and samples TREADY; slave the reverse.
// DW sets TDATA width, KW sets TKEEP width.
interface pkt_receiver_if #(
   parameter int DW = 32,
   parameter int KW = 1
);
   logic [DW-1:0] TDATA;
   logic [KW-1:0] TKEEP;
   logic          TLAST;
   logic          TVALID;
   logic          TREADY;

   modport master (output TDATA, TKEEP, TLAST, TVALID, input TREADY);
   modport slave  (input TDATA, TKEEP, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/nukv_fifogen.sv
// Generic synchronous FIFO, depth 2**ADDR_BITS, first word visible on m_axis_* without a read cycle.
// Latency: a word written at edge N is valid after edge N; m_axis_tdata reads 0 when empty.
// Backpressure: s_axis_tready = not full (independent of s_axis_tvalid); pop when m_axis_tvalid & m_axis_tready.
// Ports: clk, rst (sync, active-low, flushes), s_axis_* write side, m_axis_* read side.
module nukv_fifogen #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [DATA_SIZE-1:0] m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready
);
   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_SIZE-1:0] r_mem [DEPTH];
   logic [ADDR_BITS-1:0] r_wr_ptr;
   logic [ADDR_BITS-1:0] r_rd_ptr;
   logic [ADDR_BITS:0]   r_count;
   logic                 w_push;
   logic                 w_pop;

   // Count never exceeds DEPTH, so its MSB alone flags "full".
   assign s_axis_tready = ~r_count[ADDR_BITS];
   assign m_axis_tvalid = (r_count != '0);
   assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;

   assign w_push = s_axis_tvalid & s_axis_tready;
   assign w_pop  = m_axis_tvalid & m_axis_tready;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_axis_tdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
         if (w_pop)  r_rd_ptr <= r_rd_ptr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + {{ADDR_BITS{1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{ADDR_BITS{1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/pkt_receiver.sv
// RX packet receiver: notification -> read request -> metadata -> data beats packed for user logic.
// Latency: notification pop to read-request valid 1 cycle; accepted RX beat to pkt_tx valid 1 cycle.
// Backpressure: rx_data TREADY follows output-FIFO not-full; one read request outstanding at a time.
// Ports: clk, rst (sync, active-low); s_axis_notifications, m_axis_read_package, s_axis_rx_metadata,
//        s_axis_rx_data, pkt_tx stream bundles; stat_pkts/stat_drops/stat_len_err counters.
// Build option: define PKT_RECEIVER_STATS_EN to instantiate the counters (otherwise tied to 0).
module pkt_receiver
   import topk_net_pkg::*;
#(
   parameter int FIFO_ADDR_BITS = 5,
   parameter int DATA_W         = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   pkt_receiver_if.slave         s_axis_notifications,
   pkt_receiver_if.master        m_axis_read_package,
   pkt_receiver_if.slave         s_axis_rx_metadata,
   pkt_receiver_if.slave         s_axis_rx_data,
   pkt_receiver_if.master        pkt_tx,
   output logic [31:0]           stat_pkts,
   output logic [31:0]           stat_drops,
   output logic [31:0]           stat_len_err
);
   rx_state_e          r_state;
   logic [15:0]        r_session;
   logic [15:0]        r_len;
   logic [16:0]        r_exp_beats;
   logic [16:0]        r_beat_cnt;
   logic [15:0]        r_rx_session;

   logic [NOTIF_W-1:0] w_notif_dat;
   notif_t             w_notif;
   logic               w_notif_vld;
   logic               w_notif_pop;
   logic               w_notif_bad;
   logic               w_out_rdy;
   logic               w_beat_acc;
   logic [PKT_W-1:0]   w_out_in;
   logic [PKT_W-1:0]   w_out_dat;
   logic               w_unused;

   // ---------------- notification FIFO ----------------
   nukv_fifogen #(.DATA_SIZE(NOTIF_W), .ADDR_BITS(FIFO_ADDR_BITS)) u_notif_fifo (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_notifications.TDATA),
      .s_axis_tvalid (s_axis_notifications.TVALID),
      .s_axis_tready (s_axis_notifications.TREADY),
      .m_axis_tdata  (w_notif_dat),
      .m_axis_tvalid (w_notif_vld),
      .m_axis_tready (w_notif_pop)
   );

   assign w_notif     = w_notif_dat;
   // Only IDLE pops, so a new notification waits until the current packet has finished.
   assign w_notif_pop = (r_state == IDLE);
   assign w_notif_bad = w_notif.closed | (w_notif.length == 16'd0);

   // ---------------- handshakes ----------------
   assign m_axis_read_package.TVALID = (r_state == REQ);
   assign m_axis_read_package.TDATA  = {r_len, r_session};
   assign m_axis_read_package.TKEEP  = '1;
   assign m_axis_read_package.TLAST  = 1'b1;

   assign s_axis_rx_metadata.TREADY  = (r_state == META);
   assign s_axis_rx_data.TREADY      = (r_state == DATA) & w_out_rdy;
   assign w_beat_acc = (r_state == DATA) & s_axis_rx_data.TVALID & w_out_rdy;

   // ---------------- output FIFO ----------------
   assign w_out_in = {16'd0, r_rx_session, s_axis_rx_data.TLAST, s_axis_rx_data.TDATA[DATA_W-1:0]};

   nukv_fifogen #(.DATA_SIZE(PKT_W), .ADDR_BITS(FIFO_ADDR_BITS)) u_out_fifo (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (w_out_in),
      .s_axis_tvalid ((r_state == DATA) & s_axis_rx_data.TVALID),
      .s_axis_tready (w_out_rdy),
      .m_axis_tdata  (w_out_dat),
      .m_axis_tvalid (pkt_tx.TVALID),
      .m_axis_tready (pkt_tx.TREADY)
   );

   assign pkt_tx.TDATA = w_out_dat;
   assign pkt_tx.TLAST = w_out_dat[TLAST_BIT];
   assign pkt_tx.TKEEP = '1;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_session    <= '0;
         r_len        <= '0;
         r_exp_beats  <= '0;
         r_beat_cnt   <= '0;
         r_rx_session <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // Closed or empty sessions are consumed without a read request.
               if (w_notif_vld && !w_notif_bad) begin
                  r_session   <= w_notif.session_id;
                  r_len       <= w_notif.length;
                  r_exp_beats <= beats_for_len(w_notif.length);
                  r_state     <= REQ;
               end
            end
            REQ: begin
               if (m_axis_read_package.TREADY) r_state <= META;
            end
            META: begin
               // The stack's session ID is authoritative for the beats that follow.
               if (s_axis_rx_metadata.TVALID) begin
                  r_rx_session <= s_axis_rx_metadata.TDATA;
                  r_beat_cnt   <= '0;
                  r_state      <= DATA;
               end
            end
            DATA: begin
               if (w_beat_acc) begin
                  r_beat_cnt <= r_beat_cnt + 17'd1;
                  if (s_axis_rx_data.TLAST) r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // ---------------- statistics ----------------
`ifdef PKT_RECEIVER_STATS_EN
   logic [31:0] r_stat_pkts;
   logic [31:0] r_stat_drops;
   logic [31:0] r_stat_len_err;
   logic        w_drop;
   logic        w_last_acc;

   assign w_drop     = (r_state == IDLE) & w_notif_vld & w_notif_bad;
   assign w_last_acc = w_beat_acc & s_axis_rx_data.TLAST;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stat_pkts    <= '0;
         r_stat_drops   <= '0;
         r_stat_len_err <= '0;
      end else begin
         if (w_drop) r_stat_drops <= r_stat_drops + 32'd1;
         if (w_last_acc) begin
            r_stat_pkts <= r_stat_pkts + 32'd1;
            if ((r_beat_cnt + 17'd1) != r_exp_beats) r_stat_len_err <= r_stat_len_err + 32'd1;
         end
      end
   end

   assign stat_pkts    = r_stat_pkts;
   assign stat_drops   = r_stat_drops;
   assign stat_len_err = r_stat_len_err;
`else
   assign stat_pkts    = 32'd0;
   assign stat_drops   = 32'd0;
   assign stat_len_err = 32'd0;
`endif

   // Fields carried on the bundles that this block does not need.
   assign w_unused = ^{s_axis_notifications.TKEEP, s_axis_notifications.TLAST,
                       w_notif.rsvd, w_notif.ip, w_notif.port,
                       s_axis_rx_metadata.TKEEP, s_axis_rx_metadata.TLAST,
                       s_axis_rx_data.TKEEP, r_exp_beats, r_beat_cnt};
endmodule
